if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline: holds the PC register, addresses the instruction ROM, and owns the IF/ID pipeline register.
- Directly upstream of the ID-stage decoder/controller. Feeds that stage `instr` and PC.
- Consumes the decoder's Branch/Jal/Jr redirects and the hazard unit's stall.
- Delayed-branch architecture: the slot instruction is never flushed.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; also the base of the instruction ROM.
- IM_AW, 12, instruction ROM word-address width (4096 words).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  from hazard unit; freezes PC and IF/ID.
- branch  in  1  decoder Branch (beq taken) for the instruction in ID.
- jal  in  1  decoder Jal for the instruction in ID.
- jr  in  1  decoder Jr for the instruction in ID.
- jr_target  in  32  forwarded rs value for jr.
- im_addr  out  IM_AW  ROM word address.
- im_rdata  in  32  ROM data; combinational read of im_addr.
- if_pc  out  32  current fetch PC.
- id_instr  out  32  IF/ID instruction, to decoder `instr`.
- id_pc  out  32  PC of the instruction in ID.
- id_pc8  out  32  id_pc+8; link value for jal.

Behaviour:
- Reset (sync, reset=1 at edge): pc<=RESET_PC, id_instr<=0 (nop), id_pc<=RESET_PC, id_pc8<=RESET_PC+8. Reset wins over stall and all redirects.
- Fetch address: im_addr = (pc - RESET_PC)[IM_AW+1:2].
- Out-of-range fetch: if pc < RESET_PC or pc >= RESET_PC + 4·2^IM_AW, the word captured into IF/ID is 0 (nop) instead of im_rdata.
- Next-PC, priority order:
  1. jr: npc = jr_target.
  2. jal: npc = {id_pc4[31:28], id_instr[25:0], 2'b00}.
  3. branch: npc = id_pc4 + (sext(id_instr[15:0])<<2).
  4. otherwise: npc = pc+4.
  - id_pc4 = id_pc+4.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
- Normal cycle (stall=0):
  - pc<=npc.
  - id_instr<=fetched word, id_pc<=pc, id_pc8<=pc+8.
  - The instruction fetched in the same cycle as a taken redirect (the delay slot) enters ID unmodified.
- Stall cycle (stall=1): pc, id_instr, id_pc, id_pc8 all hold.
  - Redirect inputs are ignored; they are re-presented next cycle because the decoder still sees the held instruction.
- Latency: an instruction at pc appears on id_instr one clock after it is fetched. A redirect decoded in ID takes effect on the fetch of the following cycle, so there is exactly one delay slot.
- jr_target misaligned (low 2 bits nonzero): used as-is; im_addr drops bits [1:0]. No exception.
- Multiple redirects asserted together (decoder fault): the priority order above applies, deterministically.
- Reset mid-stall or mid-redirect: reset state is taken on that edge.
- No other state; no outputs are combinationally dependent on stall.

Decomposition:
- Shared constants package (constants include):
  - RESET_PC value.
  - NOP encoding 32'h0.
  - Field slice positions: imm16 [15:0], instr_index [25:0].
- One natural sub-module, npc_calc: purely combinational next-PC mux and target adders. Inputs: pc, id_pc, id_instr, branch, jal, jr, jr_target. Output: npc.
- PC register and IF/ID register stay in if_stage.

Test Plan:
- Reset, then 3 free cycles with ROM words A,B,C at 0x3000/04/08 -> if_pc 0x3000→0x3004→0x3008→0x300C; id_instr 0 then A, B, C; id_pc 0x3000, 0x3004, 0x3008; id_pc8 = id_pc+8.
- beq at 0x3004 with imm16=0xFFFF, branch=1 while it is in ID:
  - slot 0x3008 is fetched and enters ID;
  - next fetch is 0x3004 (0x3008 + (-4)).
- jal at 0x3010 with instr_index=0x0000C10 -> after slot 0x3014, if_pc=0x00003040; id_pc8 for the jal = 0x3018.
- jr with jr_target=0x0000301C and jal=1 simultaneously -> npc=0x301C (jr priority).
- Stall asserted 2 cycles with branch=1 during stall:
  - pc and IF/ID are unchanged both cycles;
  - after release, branch is honoured once with the correct target.
- Reset asserted mid-run with stall=1 and jr=1 -> next edge gives if_pc=0x3000, id_instr=0.
- Fetch at pc=0x7000 (beyond 4096 words) -> id_instr=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants, field positions and helpers for the fetch stage
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int          IM_AW_DEFAULT    = 12;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  localparam int IMM16_MSB = 15;
  localparam int IMM16_LSB = 0;
  localparam int INDEX_MSB = 25;
  localparam int INDEX_LSB = 0;

  typedef enum logic [1:0] {
    NPC_SEQ,
    NPC_BRANCH,
    NPC_JAL,
    NPC_JR
  } npc_sel_e;

  // Branch displacement: sign-extended word offset, converted to bytes.
  function automatic logic [31:0] branch_offset(input logic [31:0] instr);
    return {{14{instr[IMM16_MSB]}}, instr[IMM16_MSB:IMM16_LSB], 2'b00};
  endfunction

  function automatic logic [31:0] jal_target(input logic [31:0] pc4, input logic [31:0] instr);
    return {pc4[31:28], instr[INDEX_MSB:INDEX_LSB], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_npc_calc.sv
// rtl/if_stage_npc_calc.sv - combinational next-PC select and target adders
// jr outranks jal, which outranks branch; the fall-through is pc+4.
module if_stage_npc_calc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_instr,
  input  logic        branch,
  input  logic        jal,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] npc
);

  logic [31:0] id_pc4;
  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jal_pc;
  npc_sel_e    sel;
  logic        unused_opcode;

  assign id_pc4        = id_pc + 32'd4;
  assign seq_pc        = pc + 32'd4;
  assign br_pc         = id_pc4 + branch_offset(id_instr);
  assign jal_pc        = jal_target(id_pc4, id_instr);
  assign unused_opcode = ^id_instr[31:26];

  always_comb begin
    sel = NPC_SEQ;
    if (jr)          sel = NPC_JR;
    else if (jal)    sel = NPC_JAL;
    else if (branch) sel = NPC_BRANCH;
  end

  always_comb begin
    npc = seq_pc;
    unique case (sel)
      NPC_JR:     npc = jr_target;
      NPC_JAL:    npc = jal_pc;
      NPC_BRANCH: npc = br_pc;
      default:    npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC register, ROM addressing and the IF/ID register
// Delayed-branch pipeline: the word fetched alongside a redirect always proceeds to ID.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IM_AW    = IM_AW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch,
  input  logic             jal,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      if_pc,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_pc8
);

  // Computed 33 bits wide so a ROM ending exactly at 2^32 still compares correctly.
  localparam logic [32:0] IM_END = {1'b0, RESET_PC} + (33'd1 << (IM_AW + 2));

  logic [31:0] pc_off;
  logic        in_range;
  logic [31:0] fetch_word;
  logic [31:0] npc;
  logic        unused_off;

  assign pc_off     = if_pc - RESET_PC;
  assign im_addr    = pc_off[IM_AW+1:2];
  assign unused_off = ^{pc_off[31:IM_AW+2], pc_off[1:0]};

  assign in_range   = (if_pc >= RESET_PC) && ({1'b0, if_pc} < IM_END);
  assign fetch_word = in_range ? im_rdata : NOP;

  if_stage_npc_calc u_npc_calc (
    .pc        (if_pc),
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .branch    (branch),
    .jal       (jal),
    .jr        (jr),
    .jr_target (jr_target),
    .npc       (npc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      if_pc    <= RESET_PC;
      id_instr <= NOP;
      id_pc    <= RESET_PC;
      id_pc8   <= RESET_PC + 32'd8;
    end else if (!stall) begin
      if_pc    <= npc;
      id_instr <= fetch_word;
      id_pc    <= if_pc;
      id_pc8   <= if_pc + 32'd8;
    end
  end

endmodule
